ace_ccu_snoop_resp: RTL and testbench



---
 rtl/ace_ccu_snoop_resp.sv | 157 +++++++++++++++
 tb/tb_ace_ccu_snoop_resp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_ccu_snoop_resp.sv
// ---------------------------------------------------------------------------
// ace_ccu_snoop_resp
//
// Collects snoop (CR) responses for snoops issued by the snoop request stage
// and returns one merged CR response per snoop to the issuing initiator.
//
// Every issued snoop arrives as a control token {sel, idx}:
//   sel : set of snooped ports that owe one CR beat for this snoop
//   idx : initiator that receives the merged response
// Tokens are queued in a small FIFO and completed strictly in order. The head
// token collects one beat from every port in sel (OR-merging the responses),
// then presents the merged response to initiator idx until it is accepted.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   ctrl_valid_i/ready_o/ctrl_i  control token handshake, ctrl_i = {sel, idx}
//   cr_valids_i/readies_o/resps_i  CR beats from the NumOup snooped ports
//   cr_valids_o/readies_i     merged CR handshake, one-hot towards initiator idx
//   cr_resp_o                 merged CRRESP, shared by all initiators
//                             [0] DataTransfer [1] Error [2] PassDirty
//                             [3] IsShared     [4] WasUnique
// ---------------------------------------------------------------------------
module ace_ccu_snoop_resp #(
    parameter int unsigned NumInp    = 2,
    parameter int unsigned NumOup    = 1,
    parameter int unsigned CtrlDepth = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    ctrl_valid_i,
    output logic                                    ctrl_ready_o,
    input  logic [NumOup+$clog2(NumInp)-1:0]        ctrl_i,
    input  logic [NumOup-1:0]                       cr_valids_i,
    output logic [NumOup-1:0]                       cr_readies_o,
    input  logic [NumOup-1:0][4:0]                  cr_resps_i,
    output logic [NumInp-1:0]                       cr_valids_o,
    input  logic [NumInp-1:0]                       cr_readies_i,
    output logic [4:0]                              cr_resp_o
);
    localparam int unsigned IdxW  = $clog2(NumInp);
    localparam int unsigned CtrlW = NumOup + IdxW;
    localparam int unsigned PtrW  = (CtrlDepth > 1) ? $clog2(CtrlDepth) : 1;
    localparam int unsigned CntW  = $clog2(CtrlDepth + 1);

    typedef enum logic {COLLECT, RESP} state_e;

    // OR of the responses of every port that hands over a beat this cycle.
    function automatic logic [4:0] merge_resps(input logic [NumOup-1:0]      take,
                                               input logic [NumOup-1:0][4:0] resps);
        logic [4:0] merged;
        merged = '0;
        for (int j = 0; j < NumOup; j++) begin
            if (take[j]) merged = merged | resps[j];
        end
        return merged;
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(CtrlDepth - 1)) return '0;
        return ptr + PtrW'(1);
    endfunction

    logic [CtrlW-1:0]  fifo_mem_q [CtrlDepth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q,  count_d;
    state_e            state_q,  state_d;
    logic [NumOup-1:0] rcvd_q,   rcvd_d;
    logic [4:0]        acc_q,    acc_d;

    logic              push, pop, full, head_vld;
    logic [CtrlW-1:0]  head;
    logic [NumOup-1:0] head_sel, hs;
    logic [IdxW-1:0]   head_idx;
    logic [NumInp-1:0] idx_onehot;

    assign full         = (count_q == CntW'(CtrlDepth));
    // Held low while in reset so nothing is taken before the block is live.
    assign ctrl_ready_o = rst_ni & ~full;
    assign push         = ctrl_valid_i & ctrl_ready_o;
    assign head_vld     = (count_q != '0);
    assign head         = fifo_mem_q[rd_ptr_q];
    assign head_sel     = head[IdxW +: NumOup];
    assign head_idx     = head[IdxW-1:0];
    assign idx_onehot   = NumInp'(1) << head_idx;

    always_comb begin
        state_d      = state_q;
        rcvd_d       = rcvd_q;
        acc_d        = acc_q;
        pop          = 1'b0;
        hs           = '0;
        cr_readies_o = '0;
        cr_valids_o  = '0;
        cr_resp_o    = '0;
        if (head_vld) begin
            case (state_q)
                COLLECT: begin
                    // The head owns the next beat on each selected port; ports
                    // already heard from stay stalled for the following token.
                    cr_readies_o = head_sel & ~rcvd_q;
                    hs           = cr_readies_o & cr_valids_i;
                    rcvd_d       = rcvd_q | hs;
                    acc_d        = acc_q | merge_resps(hs, cr_resps_i);
                    // An empty sel is trivially covered on its first head cycle.
                    if ((rcvd_d & head_sel) == head_sel) state_d = RESP;
                end
                RESP: begin
                    cr_valids_o = idx_onehot;
                    cr_resp_o   = acc_q;
                    if ((cr_readies_i & idx_onehot) != '0) begin
                        pop     = 1'b1;
                        rcvd_d  = '0;
                        acc_d   = '0;
                        state_d = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= COLLECT;
            rcvd_q   <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            rcvd_q   <= rcvd_d;
            acc_q    <= acc_d;
        end
    end

    // Token storage carries no reset: validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= ctrl_i;
    end

endmodule

// File: tb/tb_ace_ccu_snoop_resp.sv
module tb_ace_ccu_snoop_resp;
    localparam int NI    = 3;
    localparam int NO    = 4;
    localparam int DEPTH = 2;
    localparam int IW    = 2;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                ctrl_valid_i;
    logic                ctrl_ready_o;
    logic [NO+IW-1:0]    ctrl_i;
    logic [NO-1:0]       cr_valids_i;
    logic [NO-1:0]       cr_readies_o;
    logic [NO-1:0][4:0]  cr_resps_i;
    logic [NI-1:0]       cr_valids_o;
    logic [NI-1:0]       cr_readies_i;
    logic [4:0]          cr_resp_o;

    int checks = 0;
    int errors = 0;

    ace_ccu_snoop_resp #(.NumInp(NI), .NumOup(NO), .CtrlDepth(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .ctrl_valid_i (ctrl_valid_i),
        .ctrl_ready_o (ctrl_ready_o),
        .ctrl_i       (ctrl_i),
        .cr_valids_i  (cr_valids_i),
        .cr_readies_o (cr_readies_o),
        .cr_resps_i   (cr_resps_i),
        .cr_valids_o  (cr_valids_o),
        .cr_readies_i (cr_readies_i),
        .cr_resp_o    (cr_resp_o)
    );

    always #5 clk = ~clk;

    // Reference model: pending snoops as a queue, plus what the oldest one
    // has gathered so far and whether it is waiting for its initiator.
    logic [NO-1:0] m_sel_q [$];
    logic [IW-1:0] m_idx_q [$];
    logic [NO-1:0] m_got  = '0;
    logic [4:0]    m_acc  = '0;
    bit            m_resp = 1'b0;

    function automatic bit e_ready();
        return rst_ni && (m_sel_q.size() < DEPTH);
    endfunction

    function automatic logic [NO-1:0] e_readies();
        if (!rst_ni || m_sel_q.size() == 0 || m_resp) return '0;
        return m_sel_q[0] & ~m_got;
    endfunction

    function automatic logic [NI-1:0] e_valids();
        if (!rst_ni || m_sel_q.size() == 0 || !m_resp) return '0;
        return NI'(1) << m_idx_q[0];
    endfunction

    function automatic logic [4:0] e_resp();
        if (e_valids() == '0) return '0;
        return m_acc;
    endfunction

    task automatic model_step();
        logic [NO-1:0] hs;
        bit            do_pop, do_push;
        hs      = e_readies() & cr_valids_i;
        do_push = ctrl_valid_i && e_ready();
        do_pop  = (e_valids() & cr_readies_i) != '0;
        for (int j = 0; j < NO; j++) begin
            if (hs[j]) m_acc = m_acc | cr_resps_i[j];
        end
        m_got = m_got | hs;
        if (m_sel_q.size() != 0 && !m_resp && ((m_got & m_sel_q[0]) == m_sel_q[0]))
            m_resp = 1'b1;
        if (do_pop) begin
            void'(m_sel_q.pop_front());
            void'(m_idx_q.pop_front());
            m_got  = '0;
            m_acc  = '0;
            m_resp = 1'b0;
        end
        if (do_push) begin
            m_sel_q.push_back(ctrl_i[IW +: NO]);
            m_idx_q.push_back(ctrl_i[IW-1:0]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                m_sel_q.delete();
                m_idx_q.delete();
                m_got  = '0;
                m_acc  = '0;
                m_resp = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_ctrl_ready", 32'(ctrl_ready_o), 32'(e_ready()));
            chk("m_cr_readies", 32'(cr_readies_o), 32'(e_readies()));
            chk("m_cr_valids",  32'(cr_valids_o),  32'(e_valids()));
            chk("m_cr_resp",    32'(cr_resp_o),    32'(e_resp()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ctrl_valid_i = 1'b0;
        while (m_sel_q.size() != 0 && n < 100) begin
            cr_valids_i  = '1;
            for (int j = 0; j < NO; j++) cr_resps_i[j] = 5'($urandom);
            cr_readies_i = '1;
            tick();
            n++;
        end
        chk("drain_bound", 32'(n < 100), 32'd1);
        cr_valids_i  = '0;
        cr_readies_i = '0;
        cr_resps_i   = '0;
        tick();
    endtask

    initial begin
        rst_ni       = 1'b0;
        ctrl_valid_i = 1'b0;
        ctrl_i       = '0;
        cr_valids_i  = '0;
        cr_resps_i   = '0;
        cr_readies_i = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl_ready", 32'(ctrl_ready_o), 32'd0);
        chk("rst_cr_valids",  32'(cr_valids_o),  32'd0);
        chk("rst_cr_readies", 32'(cr_readies_o), 32'd0);
        chk("rst_cr_resp",    32'(cr_resp_o),    32'd0);
        rst_ni = 1'b1;
        #1;
        chk("rel_ctrl_ready", 32'(ctrl_ready_o), 32'd1);

        // single token sel=0101 idx=2, beats on ports 0 and 2
        tick(); ctrl_valid_i = 1'b1; ctrl_i = {4'b0101, 2'd2};
        tick(); ctrl_valid_i = 1'b0; cr_valids_i = 4'b0001; cr_resps_i[0] = 5'b00001;
        chk("t1_rdy_c1", 32'(cr_readies_o), 32'b0101);
        tick(); cr_valids_i = 4'b0000;
        chk("t1_rdy_c2", 32'(cr_readies_o), 32'b0100);
        tick(); cr_valids_i = 4'b0100; cr_resps_i[2] = 5'b01000;
        tick(); cr_valids_i = 4'b0000; cr_readies_i = 3'b100;
        chk("t1_valids", 32'(cr_valids_o), 32'b100);
        chk("t1_resp",   32'(cr_resp_o),   32'b01001);
        tick(); cr_readies_i = 3'b000; cr_resps_i = '0;
        chk("t1_popped", 32'(cr_valids_o), 32'd0);

        // empty sel completes without touching any port
        tick(); ctrl_valid_i = 1'b1; ctrl_i = {4'b0000, 2'd1};
        tick(); ctrl_valid_i = 1'b0;
        chk("t2_rdy",      32'(cr_readies_o), 32'd0);
        chk("t2_not_yet",  32'(cr_valids_o),  32'd0);
        tick(); cr_readies_i = 3'b010;
        chk("t2_valids", 32'(cr_valids_o), 32'b010);
        chk("t2_resp",   32'(cr_resp_o),   32'd0);
        tick(); cr_readies_i = 3'b000;

        // all four ports answer in the same cycle
        tick(); ctrl_valid_i = 1'b1; ctrl_i = {4'b1111, 2'd0};
        tick(); ctrl_valid_i = 1'b0; cr_valids_i = 4'b1111;
        cr_resps_i = {5'b01000, 5'b00000, 5'b00100, 5'b00010};
        chk("t3_rdy", 32'(cr_readies_o), 32'b1111);
        tick(); cr_valids_i = 4'b0000; cr_readies_i = 3'b001;
        chk("t3_valids", 32'(cr_valids_o), 32'b001);
        chk("t3_resp",   32'(cr_resp_o),   32'b01110);
        tick(); cr_readies_i = 3'b000; cr_resps_i = '0;

        // FIFO fills at two tokens; ready returns the cycle after the pop
        tick(); ctrl_valid_i = 1'b1; ctrl_i = {4'b0001, 2'd0};
        chk("t4_ready_c0", 32'(ctrl_ready_o), 32'd1);
        tick(); chk("t4_ready_c1", 32'(ctrl_ready_o), 32'd1);
        tick(); chk("t4_ready_c2", 32'(ctrl_ready_o), 32'd0);
        tick(); cr_valids_i = 4'b0001; cr_resps_i[0] = 5'b00001;
        chk("t4_ready_c3", 32'(ctrl_ready_o), 32'd0);
        tick(); cr_valids_i = 4'b0000; cr_readies_i = 3'b001;
        chk("t4_ready_c4",  32'(ctrl_ready_o), 32'd0);
        chk("t4_valids_c4", 32'(cr_valids_o),  32'b001);
        tick(); cr_readies_i = 3'b000;
        chk("t4_ready_c5", 32'(ctrl_ready_o), 32'd1);
        tick(); ctrl_valid_i = 1'b0;
        drain();

        // initiator backpressure for five cycles
        tick(); ctrl_valid_i = 1'b1; ctrl_i = {4'b0010, 2'd1};
        tick(); ctrl_i = {4'b0010, 2'd2}; cr_valids_i = 4'b0010; cr_resps_i[1] = 5'b10000;
        tick(); ctrl_valid_i = 1'b0; cr_resps_i[1] = 5'b00001;
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valids",  32'(cr_valids_o),  32'b010);
            chk("t5_hold_resp",    32'(cr_resp_o),    32'b10000);
            chk("t5_hold_readies", 32'(cr_readies_o), 32'd0);
            tick();
        end
        cr_readies_i = 3'b010;
        chk("t5_still_valid", 32'(cr_valids_o), 32'b010);
        tick(); cr_readies_i = 3'b000;
        chk("t5_next_rdy", 32'(cr_readies_o), 32'b0010);
        tick(); cr_valids_i = 4'b0000; cr_readies_i = 3'b100;
        chk("t5_b_valids", 32'(cr_valids_o), 32'b100);
        chk("t5_b_resp",   32'(cr_resp_o),   32'b00001);
        tick(); cr_readies_i = 3'b000; cr_resps_i = '0;

        // reset with two tokens pending and one beat already collected
        tick(); ctrl_valid_i = 1'b1; ctrl_i = {4'b0011, 2'd0};
        tick(); ctrl_i = {4'b0001, 2'd1}; cr_valids_i = 4'b0001; cr_resps_i[0] = 5'b00010;
        tick(); ctrl_valid_i = 1'b0; cr_valids_i = 4'b0000;
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_ready",   32'(ctrl_ready_o), 32'd0);
        chk("t6_rst_readies", 32'(cr_readies_o), 32'd0);
        chk("t6_rst_valids",  32'(cr_valids_o),  32'd0);
        chk("t6_rst_resp",    32'(cr_resp_o),    32'd0);
        tick(); rst_ni = 1'b1;
        #1;
        chk("t6_rel_ready",   32'(ctrl_ready_o), 32'd1);
        chk("t6_rel_readies", 32'(cr_readies_o), 32'd0);
        tick(); ctrl_valid_i = 1'b1; ctrl_i = {4'b0100, 2'd2};
        tick(); ctrl_valid_i = 1'b0; cr_valids_i = 4'b0100; cr_resps_i[2] = 5'b00100;
        chk("t6_fresh_rdy", 32'(cr_readies_o), 32'b0100);
        tick(); cr_valids_i = 4'b0000; cr_readies_i = 3'b100;
        chk("t6_fresh_valids", 32'(cr_valids_o), 32'b100);
        chk("t6_fresh_resp",   32'(cr_resp_o),   32'b00100);
        tick(); cr_readies_i = 3'b000; cr_resps_i = '0;

        // randomized traffic, with occasional asynchronous reset pulses
        for (int c = 0; c < 4000; c++) begin
            ctrl_valid_i = 1'($urandom_range(0, 1));
            ctrl_i       = {4'($urandom), 2'($urandom_range(0, NI - 1))};
            cr_valids_i  = 4'($urandom);
            for (int j = 0; j < NO; j++) cr_resps_i[j] = 5'($urandom);
            cr_readies_i = 3'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst_ni = 1'b0;
                #2;
                rst_ni = 1'b1;
            end
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
